// File: rtl/multi_decode_queue_pkg.sv
// Shared types for the multi-lane decode queue: decoded control word, ALU ops, opcodes, immediates.
// The RV32M extension is enabled by defining MULTI_DECODE_RV32M_EN (see the decode lane).
package multi_decode_queue_pkg;

    localparam int PC_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J
    } encoding_type;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS
    } alu_op_type;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        encoding_type    encoding;
        alu_op_type      alu_op;
        logic            reg_write;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            is_branch;
        logic            is_jump;
        logic            is_jumpr;
        logic            is_lui;
        logic            is_auipc;
        logic            is_mul;
        logic            is_div;
        logic            rs1_valid;
        logic            rs2_valid;
        logic            predict;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } decoded_type;

    function automatic logic [31:0] immediate_extension(input logic [31:0] instr,
                                                        input encoding_type enc);
        case (enc)
            ENC_I:   return {{20{instr[31]}}, instr[31:20]};
            ENC_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ENC_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ENC_U:   return {instr[31:12], 12'b0};
            ENC_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

    // alt selects the funct7[5] variant (SUB / SRA) where the funct3 has one
    function automatic alu_op_type alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multi_decode_queue_decode_lane.sv
// Purely combinational single-instruction RV32I decoder producing one decoded_type word.
// Defining MULTI_DECODE_RV32M_EN adds MUL/DIV decode for OP with funct7=0000001.
module multi_decode_queue_decode_lane
    import multi_decode_queue_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_predict,
    output decoded_type     o_ctrl
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        o_ctrl          = '0;
        o_ctrl.rd       = i_instr[11:7];
        o_ctrl.rs1      = i_instr[19:15];
        o_ctrl.rs2      = i_instr[24:20];
        o_ctrl.funct3   = w_funct3;
        o_ctrl.pc       = i_pc;
        o_ctrl.predict  = i_predict;
        o_ctrl.encoding = ENC_R;
        o_ctrl.alu_op   = ALU_ADD;

        case (w_opcode)
            OPC_LUI: begin
                o_ctrl.encoding  = ENC_U;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.is_lui    = 1'b1;
                o_ctrl.alu_op    = ALU_PASS;
            end
            OPC_AUIPC: begin
                o_ctrl.encoding  = ENC_U;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.is_auipc  = 1'b1;
            end
            OPC_JAL: begin
                o_ctrl.encoding  = ENC_J;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.is_jump   = 1'b1;
            end
            OPC_JALR: begin
                o_ctrl.encoding  = ENC_I;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.is_jumpr  = 1'b1;
                o_ctrl.rs1_valid = 1'b1;
            end
            OPC_BRANCH: begin
                o_ctrl.encoding  = ENC_B;
                o_ctrl.is_branch = 1'b1;
                o_ctrl.rs1_valid = 1'b1;
                o_ctrl.rs2_valid = 1'b1;
                // equality compares subtract; ordered compares use the set-less-than units
                o_ctrl.alu_op    = (w_funct3[2:1] == 2'b00) ? ALU_SUB :
                                   (w_funct3[1]) ? ALU_SLTU : ALU_SLT;
            end
            OPC_LOAD: begin
                o_ctrl.encoding   = ENC_I;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.rs1_valid  = 1'b1;
            end
            OPC_STORE: begin
                o_ctrl.encoding  = ENC_S;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.rs1_valid = 1'b1;
                o_ctrl.rs2_valid = 1'b1;
            end
            OPC_OP_IMM: begin
                o_ctrl.encoding  = ENC_I;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.rs1_valid = 1'b1;
                o_ctrl.alu_op    = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                // only the shift forms carry a funct7; SLLI has no arithmetic variant
                if ((w_funct3 == 3'b001 && w_funct7 != F7_BASE) ||
                    (w_funct3 == 3'b101 && w_funct7 != F7_BASE && w_funct7 != F7_ALT))
                    o_ctrl.illegal = 1'b1;
            end
            OPC_OP: begin
                o_ctrl.encoding  = ENC_R;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.rs1_valid = 1'b1;
                o_ctrl.rs2_valid = 1'b1;
                case (w_funct7)
                    F7_BASE: o_ctrl.alu_op = alu_from_funct3(w_funct3, 1'b0);
                    F7_ALT: begin
                        if (w_funct3 == 3'b000 || w_funct3 == 3'b101)
                            o_ctrl.alu_op = alu_from_funct3(w_funct3, 1'b1);
                        else
                            o_ctrl.illegal = 1'b1;
                    end
`ifdef MULTI_DECODE_RV32M_EN
                    F7_MULDIV: begin
                        o_ctrl.is_mul = ~w_funct3[2];
                        o_ctrl.is_div = w_funct3[2];
                    end
`endif
                    default: o_ctrl.illegal = 1'b1;
                endcase
            end
            default: o_ctrl.illegal = 1'b1;
        endcase

        o_ctrl.imm = immediate_extension(i_instr, o_ctrl.encoding);

        // illegal words still travel down the queue, but must never touch state
        if (o_ctrl.illegal) begin
            o_ctrl.reg_write = 1'b0;
            o_ctrl.mem_read  = 1'b0;
            o_ctrl.mem_write = 1'b0;
            o_ctrl.is_mul    = 1'b0;
            o_ctrl.is_div    = 1'b0;
        end
    end

endmodule

// File: rtl/multi_decode_queue.sv
// Multi-lane decoder feeding a circular decode queue; valid lanes are compacted in program order.
// Optional RV32M decode is selected with MULTI_DECODE_RV32M_EN inside the decode lanes.
module multi_decode_queue
    import multi_decode_queue_pkg::*;
#(
    parameter int DECODE_WIDTH = 2,
    parameter int QUEUE_DEPTH  = 8,
    parameter int XLEN         = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush,
    input  logic [DECODE_WIDTH-1:0]                   in_valid,
    input  logic [DECODE_WIDTH*32-1:0]                in_instr,
    input  logic [DECODE_WIDTH*XLEN-1:0]              in_pc,
    input  logic [DECODE_WIDTH-1:0]                   in_predict,
    output logic                                      in_ready,
    output logic [DECODE_WIDTH-1:0]                   out_valid,
    output logic [DECODE_WIDTH*$bits(decoded_type)-1:0] out_ctrl,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]         out_deq,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]          occupancy
);

    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH+1);
    localparam int CTRL_W = $bits(decoded_type);

    decoded_type      r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    decoded_type      w_dec [DECODE_WIDTH];
    logic [PTR_W-1:0] w_ofs [DECODE_WIDTH];
    logic [CNT_W-1:0] w_k;
    logic [CNT_W-1:0] w_deq_n;
    logic             w_enq;

    for (genvar l = 0; l < DECODE_WIDTH; l++) begin : g_lane
        multi_decode_queue_decode_lane u_lane (
            .i_instr   (in_instr[l*32 +: 32]),
            .i_pc      (PC_W'(in_pc[l*XLEN +: XLEN])),
            .i_predict (in_predict[l]),
            .o_ctrl    (w_dec[l])
        );
    end

    // Each valid lane lands at tail plus the number of valid lanes older than it
    always_comb begin
        w_k = '0;
        for (int l = 0; l < DECODE_WIDTH; l++) begin
            w_ofs[l] = w_k[PTR_W-1:0];
            w_k      = w_k + CNT_W'(in_valid[l]);
        end
    end

    // Ready looks only at the registered count so out_deq never reaches in_ready
    assign in_ready  = (r_count <= CNT_W'(QUEUE_DEPTH - DECODE_WIDTH));
    assign w_enq     = in_ready && (|in_valid) && !flush;
    assign w_deq_n   = (CNT_W'(out_deq) > r_count) ? r_count : CNT_W'(out_deq);
    assign occupancy = r_count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + w_k[PTR_W-1:0];
            r_head  <= r_head + w_deq_n[PTR_W-1:0];
            r_count <= r_count + (w_enq ? w_k : '0) - w_deq_n;
        end
    end

    // Storage is not reset; stale entries are masked by the count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int l = 0; l < DECODE_WIDTH; l++) begin
                if (in_valid[l])
                    r_mem[r_tail + w_ofs[l]] <= w_dec[l];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            out_valid[i]                 = (r_count > CNT_W'(i));
            out_ctrl[i*CTRL_W +: CTRL_W] = r_mem[r_head + PTR_W'(i)];
        end
    end

endmodule

// File: tb/tb_multi_decode_queue.sv
// Scoreboard bench for multi_decode_queue: stimulus pushes hand-computed entries, a monitor pops on dequeue.
module tb_multi_decode_queue;
    import multi_decode_queue_pkg::*;

    localparam int DW = 2;
    localparam int QD = 8;
    localparam int XL = 32;
    localparam int CW = $bits(decoded_type);

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_type  alu;
        logic        chk_alu;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mul;
        logic        ill;
        logic        pred;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [DW-1:0]        in_valid;
    logic [DW*32-1:0]     in_instr;
    logic [DW*XL-1:0]     in_pc;
    logic [DW-1:0]        in_predict;
    logic                 in_ready;
    logic [DW-1:0]        out_valid;
    logic [DW*CW-1:0]     out_ctrl;
    logic [1:0]           out_deq;
    logic [3:0]           occupancy;

    int   total = 0;
    int   bad   = 0;
    int   occ   = 0;
    logic [31:0] pc_base = 32'h1000;
    exp_t sb[$];

    always #5 clk = ~clk;

    multi_decode_queue #(.DECODE_WIDTH(DW), .QUEUE_DEPTH(QD), .XLEN(XL)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_predict (in_predict),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ctrl   (out_ctrl),
        .out_deq    (out_deq),
        .occupancy  (occupancy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] imm, input alu_op_type alu,
                                input logic chk_alu, input logic rw, input logic mr, input logic mw,
                                input logic mul, input logic ill);
        exp_t e;
        e.pc = '0; e.rd = rd; e.imm = imm; e.alu = alu; e.chk_alu = chk_alu;
        e.rw = rw; e.mr = mr; e.mw = mw; e.mul = mul; e.ill = ill; e.pred = 1'b0;
        return e;
    endfunction

    // ADDI x1, x0, n
    function automatic logic [31:0] addi(input int n);
        logic [11:0] im;
        im = 12'(n);
        return {im, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    function automatic exp_t ea(input int n);
        return mk(5'd1, 32'(n), ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Monitor: every head lane consumed this cycle must match the oldest expected entry
    always @(negedge clk) begin
        decoded_type md;
        exp_t        me;
        if (!reset && !flush) begin
            for (int i = 0; i < DW; i++) begin
                if (i < int'(out_deq) && out_valid[i]) begin
                    md = out_ctrl[i*CW +: CW];
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard_empty lane%0d: got pc %0h want no entry", i, md.pc);
                    end else begin
                        me = sb.pop_front();
                        chk("pc", md.pc, me.pc);
                        chk("illegal", 32'(md.illegal), 32'(me.ill));
                        chk("reg_write", 32'(md.reg_write), 32'(me.rw));
                        chk("mem_read", 32'(md.mem_read), 32'(me.mr));
                        chk("mem_write", 32'(md.mem_write), 32'(me.mw));
                        chk("is_mul", 32'(md.is_mul), 32'(me.mul));
                        chk("predict", 32'(md.predict), 32'(me.pred));
                        if (me.rw)
                            chk("rd", 32'(md.rd), 32'(me.rd));
                        if (!me.ill)
                            chk("imm", md.imm, me.imm);
                        if (me.chk_alu)
                            chk("alu_op", 32'(md.alu_op), 32'(me.alu));
                    end
                end
            end
        end
    end

    task automatic cycle(input logic [1:0] v, input logic [31:0] i0, input exp_t e0,
                         input logic [31:0] i1, input exp_t e1, input logic [1:0] deq,
                         input logic fl, input logic rs);
        exp_t t;
        logic enq;
        int   dn;
        int   therm;
        in_valid   = v;
        in_instr   = {i1, i0};
        in_pc      = {pc_base + 32'd4, pc_base};
        in_predict = 2'b10;
        out_deq    = deq;
        flush      = fl;
        reset      = rs;
        enq = !rs && !fl && (occ <= QD - DW) && (v != 2'b00);
        if (enq) begin
            if (v[0]) begin t = e0; t.pc = pc_base;         t.pred = 1'b0; sb.push_back(t); end
            if (v[1]) begin t = e1; t.pc = pc_base + 32'd4; t.pred = 1'b1; sb.push_back(t); end
        end
        pc_base += 32'd8;
        @(negedge clk);
        therm = (occ >= 2) ? 3 : (occ == 1) ? 1 : 0;
        chk("occupancy", 32'(occupancy), 32'(occ));
        chk("in_ready", 32'(in_ready), 32'(occ <= QD - DW));
        chk("out_valid", 32'(out_valid), 32'(therm));
        @(posedge clk);
        if (rs || fl) begin
            occ = 0;
            sb.delete();
        end else begin
            dn  = (int'(deq) > occ) ? occ : int'(deq);
            occ = occ + (enq ? (int'(v[0]) + int'(v[1])) : 0) - dn;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e_addi5, e_sub, e_lw, e_mul, e_bad, e_sw, e_beq, e_lui, e_x;
        e_addi5 = mk(5'd1, 32'd5, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e_sub   = mk(5'd3, 32'd0, ALU_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e_lw    = mk(5'd5, 32'd8, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MULTI_DECODE_RV32M_EN
        e_mul   = mk(5'd4, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        e_mul   = mk(5'd4, 32'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        e_bad   = mk(5'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e_sw    = mk(5'd0, 32'hFFFF_FFFC, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_beq   = mk(5'd0, 32'hFFFF_FFF8, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_lui   = mk(5'd7, 32'h1234_5000, ALU_PASS, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e_x     = e_addi5;

        reset = 1'b1; flush = 1'b0; in_valid = '0; in_instr = '0; in_pc = '0;
        in_predict = '0; out_deq = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // two lanes decoded, then drained
        cycle(2'b11, 32'h0050_0093, e_addi5, 32'h4020_81B3, e_sub, 2'd0, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd0, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd2, 1'b0, 1'b0);
        // hole in lane 0 compacts LW to the head; over-dequeue clips; empty dequeue ignored
        cycle(2'b10, 32'h0, e_x, 32'h0081_2283, e_lw, 2'd0, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd2, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd2, 1'b0, 1'b0);
        // fill to full, hold a group, then free two slots
        for (int j = 0; j < 4; j++)
            cycle(2'b11, addi(10 + 2*j), ea(10 + 2*j), addi(11 + 2*j), ea(11 + 2*j), 2'd0, 1'b0, 1'b0);
        cycle(2'b11, addi(100), ea(100), addi(101), ea(101), 2'd0, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd2, 1'b0, 1'b0);
        // steady state at 6 entries: pointers wrap several times
        for (int j = 0; j < 10; j++)
            cycle(2'b11, addi(200 + 2*j), ea(200 + 2*j), addi(201 + 2*j), ea(201 + 2*j), 2'd2, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd1, 1'b0, 1'b0);
        // flush at 5 entries with enqueue and dequeue in the same cycle
        cycle(2'b11, addi(300), ea(300), addi(301), ea(301), 2'd2, 1'b1, 1'b0);
        // MUL, undefined opcode, store/branch immediates, LUI
        cycle(2'b11, 32'h0220_8233, e_mul, 32'h0000_007F, e_bad, 2'd0, 1'b0, 1'b0);
        cycle(2'b11, 32'hFE20_AE23, e_sw, 32'hFE20_8CE3, e_beq, 2'd2, 1'b0, 1'b0);
        cycle(2'b01, 32'h1234_53B7, e_lui, 32'h0, e_x, 2'd2, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd1, 1'b0, 1'b0);
        // reset in the middle of traffic
        cycle(2'b11, addi(400), ea(400), addi(401), ea(401), 2'd0, 1'b0, 1'b0);
        cycle(2'b11, addi(500), ea(500), addi(501), ea(501), 2'd2, 1'b0, 1'b1);
        cycle(2'b00, 32'h0, e_x, 32'h0, e_x, 2'd0, 1'b0, 1'b0);

        chk("scoreboard_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
